// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO and a
// STATUS word readable by the core over the IO load/store path.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  io_addr,
  input  logic        io_wstrb,
  input  logic [31:0] io_wdata,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        TXD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          txd_q;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;
  logic [31:0]   rdata_q;

  logic       full;
  logic       empty;
  logic       baud_end;
  logic       busy;
  logic       pop;
  logic       push_req;
  logic       push;
  logic [7:0] status;
  logic       unused_wdata;

  assign unused_wdata = ^io_wdata[31:8];

  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    baud_end = (baud_q == BAUD_LAST);
    busy     = (state_q != IDLE) || !empty;
    // The shifter takes the head either from IDLE or at the last stop-bit cycle.
    pop      = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
    push_req = io_wstrb && (io_addr == 2'd0);
    push     = push_req && (!full || pop);

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    ovf_d = ovf_q;
    if (io_rstrb && (io_addr == 2'd1)) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end

    status = {4'(count_q), ovf_q, empty, full, busy};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= io_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (io_rstrb) begin
        rdata_q <= (io_addr == 2'd1) ? {24'd0, status} : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= mem_q[rptr_q];
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= shreg_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shreg_q   <= shreg_q >> 1;
              txd_q     <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shreg_q <= mem_q[rptr_q];
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_rdata = rdata_q;
  assign TXD      = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: queue/frame-position reference model checked every
// cycle, a UART receiver on TXD, and literal checks of the key scenarios.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk      = 1'b0;
  logic        resetn   = 1'b0;
  logic [1:0]  io_addr  = 2'd0;
  logic        io_wstrb = 1'b0;
  logic [31:0] io_wdata = 32'd0;
  logic        io_rstrb = 1'b0;
  logic [31:0] io_rdata;
  logic        TXD;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .io_addr  (io_addr),
    .io_wstrb (io_wstrb),
    .io_wdata (io_wdata),
    .io_rstrb (io_rstrb),
    .io_rdata (io_rdata),
    .TXD      (TXD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the position inside the frame on the wire.
  logic [7:0]  m_q[$];
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  logic [7:0]  m_cur    = 8'd0;
  bit          m_ovf    = 1'b0;
  logic [31:0] m_rdata  = 32'd0;
  bit          m_valid  = 1'b0;

  always @(posedge clk) begin : model
    bit         pop;
    bit         ovf_set;
    logic [7:0] st;
    if (!resetn) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_rdata  = 32'd0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      pop = (m_q.size() > 0) && (!m_active || (m_pos == FRAME - 1));
      st  = {4'(m_q.size()), m_ovf, (m_q.size() == 0), (m_q.size() == DEP),
             (m_active || (m_q.size() != 0))};
      ovf_set = 1'b0;
      if (io_rstrb) m_rdata = (io_addr == 2'd1) ? {24'd0, st} : 32'd0;
      if (pop) m_cur = m_q.pop_front();
      if (io_wstrb && (io_addr == 2'd0)) begin
        if (m_q.size() < DEP) m_q.push_back(io_wdata[7:0]);
        else ovf_set = 1'b1;
      end
      if (io_rstrb && (io_addr == 2'd1)) m_ovf = 1'b0;
      if (ovf_set) m_ovf = 1'b1;
      if (m_active && (m_pos != FRAME - 1)) m_pos++;
      else if (pop) begin
        m_active = 1'b1;
        m_pos    = 0;
      end else m_active = 1'b0;
    end
  end

  function automatic logic exp_txd();
    logic [9:0] fr;
    if (!m_active) return 1'b1;
    fr = {1'b1, m_cur, 1'b0};
    return fr[m_pos / CPB];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_txd", {31'd0, TXD}, {31'd0, exp_txd()});
      check("cyc_rdata", io_rdata, m_rdata);
    end
  end

  // Independent receiver sampling the middle of each bit on TXD.
  int         rx_cnt = -1;
  logic [7:0] rx_sh  = 8'd0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!resetn) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (TXD === 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB == CPB / 2) && (rx_cnt / CPB >= 1) && (rx_cnt / CPB <= 8))
        rx_sh[rx_cnt / CPB - 1] = TXD;
      if (rx_cnt == FRAME - 1) begin
        rx_q.push_back(rx_sh);
        rx_cnt = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] d);
    io_addr  = 2'd0;
    io_wdata = {24'($urandom), d};
    io_wstrb = 1'b1;
    tick();
    io_wstrb = 1'b0;
  endtask

  task automatic rd_status();
    io_addr  = 2'd1;
    io_rstrb = 1'b1;
    tick();
    io_rstrb = 1'b0;
  endtask

  task automatic do_reset();
    io_wstrb = 1'b0;
    io_rstrb = 1'b0;
    resetn   = 1'b0;
    ticks(2);
    resetn   = 1'b1;
  endtask

  task automatic check_rx(input string name, input logic [7:0] first, input int n);
    check({name, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, first + 8'(i)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [9:0] lit;
    int n;

    // 1: idle status after reset
    do_reset();
    rd_status();
    check("idle_status", io_rdata, 32'h4);
    check("idle_txd", {31'd0, TXD}, 32'd1);

    // 2: single byte 0xA5, frame shape and busy release
    lit = {1'b1, 8'hA5, 1'b0};
    wr(8'hA5);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k % CPB == 2) check("single_bit", {31'd0, TXD}, {31'd0, lit[k / CPB]});
    end
    rd_status();
    check("single_busy_last", io_rdata, 32'h5);
    rd_status();
    check("single_busy_off", io_rdata, 32'h4);
    check("model_busy_off", m_rdata, 32'h4);

    // 3: back-to-back frames, 120 contiguous cycles
    rx_q.delete();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    ticks(118);
    rd_status();
    check("b2b_busy_last", io_rdata, 32'h5);
    rd_status();
    check("b2b_done", io_rdata, 32'h4);
    check_rx("b2b_rx", 8'h01, 3);

    // 4: overflow and sticky clear
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    rd_status();
    check("ovf_status", io_rdata, 32'h4B);
    check("model_ovf_status", m_rdata, 32'h4B);
    rd_status();
    check("ovf_cleared", io_rdata, 32'h43);
    ticks(5 * FRAME + 10);
    check_rx("ovf_rx", 8'h10, 5);

    // 5: reset in the data bits of the second frame
    do_reset();
    rx_q.delete();
    wr(8'hA1);
    wr(8'hB2);
    wr(8'hC3);
    ticks(55);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("rst_txd", {31'd0, TXD}, 32'd1);
    rd_status();
    check("rst_status", io_rdata, 32'h4);
    ticks(3 * FRAME);
    check("rst_rx_count", 32'(rx_q.size()), 32'd1);

    // 6: push in the exact cycle the shifter pops from a full FIFO
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i));
    n = 0;
    while (!(m_active && (m_pos == FRAME - 1)) && (n < 200)) begin
      tick();
      n++;
    end
    check("pp_wait", 32'(n < 200), 32'd1);
    wr(8'h25);
    rd_status();
    check("pp_status", io_rdata, 32'h43);
    ticks(6 * FRAME);
    check_rx("pp_rx", 8'h20, 6);

    // Randomized traffic with varying write pressure and rare resets
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        io_addr  = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
        io_wdata = $urandom;
        io_wstrb = ($urandom_range(0, 99) < 5 + seg * 12);
        io_rstrb = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 999) == 0) resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end
    end
    io_wstrb = 1'b0;
    io_rstrb = 1'b0;
    ticks(5 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
